// File: rtl/square_seq_pkg.sv
// Shared widths and FSM state type for the square sequence generator.
`default_nettype none
package square_seq_pkg;
  localparam int IDX_W = 16;
  localparam int SQR_W = 2 * IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEED   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
endpackage
`default_nettype wire

// File: rtl/square_step.sv
// Incremental square generator: holds (n^2, 2n+1) and steps to (n+1)^2 per advance.
`default_nettype none
module square_step #(
  parameter int SQR_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [SQR_W-1:0] i_load_sqr,
  input  logic [SQR_W-1:0] i_load_odd,
  input  logic             i_advance,
  output logic [SQR_W-1:0] o_sqr
);
  logic [SQR_W-1:0] r_sqr;
  logic [SQR_W-1:0] r_odd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sqr <= '0;
      r_odd <= '0;
    end else if (i_load) begin
      r_sqr <= i_load_sqr;
      r_odd <= i_load_odd;
    end else if (i_advance) begin
      // (n+1)^2 = n^2 + (2n+1); everything wraps modulo 2^SQR_W
      r_sqr <= r_sqr + r_odd;
      r_odd <= r_odd + SQR_W'(2);
    end
  end

  assign o_sqr = r_sqr;
endmodule
`default_nettype wire

// File: rtl/square_seq_ctrl.sv
// Command FSM: seeds n0^2 with a serial shift-add multiplier, then streams (n0+k)^2.
`default_nettype none
module square_seq_ctrl #(
  parameter int IDX_W = square_seq_pkg::IDX_W,
  parameter int SQR_W = square_seq_pkg::SQR_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [IDX_W-1:0] cmd_start_i,
  input  logic [IDX_W-1:0] cmd_count_i,
  input  logic             abort_i,
  output logic             sqr_valid_o,
  input  logic             sqr_ready_i,
  output logic [SQR_W-1:0] sqr_o,
  output logic             sqr_last_o,
  output logic             busy_o,
  output logic             done_o
);
  import square_seq_pkg::*;

  localparam int CW = $clog2(IDX_W);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_n0;
  logic [IDX_W-1:0] r_count;
  logic [IDX_W-1:0] r_mq;
  logic [SQR_W-1:0] r_md;
  logic [SQR_W-1:0] r_acc;
  logic [CW-1:0]    r_seed_cnt;

  logic             w_accept;
  logic             w_xfer;
  logic             w_seed_done;
  logic [SQR_W-1:0] w_acc_next;

  assign w_accept    = cmd_valid_i && (r_state == ST_IDLE);
  assign w_xfer      = sqr_valid_o && sqr_ready_i;
  assign w_seed_done = (r_state == ST_SEED) && (r_seed_cnt == CW'(IDX_W - 1));
  assign w_acc_next  = r_acc + (r_mq[0] ? r_md : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = (cmd_count_i == '0) ? ST_DONE : ST_SEED;
      ST_SEED:   if (abort_i) w_next = ST_IDLE;
                 else if (w_seed_done) w_next = ST_STREAM;
      ST_STREAM: if (abort_i) w_next = ST_IDLE;
                 else if (w_xfer && sqr_last_o) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // One multiplier bit per SEED cycle: acc += md when the low bit of mq is set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_n0       <= '0;
      r_count    <= '0;
      r_mq       <= '0;
      r_md       <= '0;
      r_acc      <= '0;
      r_seed_cnt <= '0;
    end else if (w_accept) begin
      r_n0       <= cmd_start_i;
      r_count    <= cmd_count_i;
      r_mq       <= cmd_start_i;
      r_md       <= SQR_W'(cmd_start_i);
      r_acc      <= '0;
      r_seed_cnt <= '0;
    end else if (r_state == ST_SEED) begin
      r_acc      <= w_acc_next;
      r_md       <= r_md << 1;
      r_mq       <= r_mq >> 1;
      r_seed_cnt <= r_seed_cnt + CW'(1);
    end else if (w_xfer) begin
      r_count    <= r_count - IDX_W'(1);
    end
  end

  square_step #(
    .SQR_W (SQR_W)
  ) u_step (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_seed_done),
    .i_load_sqr (w_acc_next),
    .i_load_odd (SQR_W'({r_n0, 1'b1})),
    .i_advance  (w_xfer),
    .o_sqr      (sqr_o)
  );

  assign cmd_ready_o = (r_state == ST_IDLE);
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = (r_state == ST_DONE);
  assign sqr_valid_o = (r_state == ST_STREAM);
  assign sqr_last_o  = sqr_valid_o && (r_count == IDX_W'(1));
endmodule
`default_nettype wire

// File: tb/tb_square_seq_ctrl.sv
// Randomized self-checking bench for square_seq_ctrl against an arithmetic (n0+k)^2 model.
`default_nettype none
module tb_square_seq_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid_i, abort_i, sqr_ready_i;
  logic [15:0] cmd_start_i, cmd_count_i;
  logic        cmd_ready_o, sqr_valid_o, sqr_last_o, busy_o, done_o;
  logic [31:0] sqr_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] beats[$];
  bit          lasts[$];
  int          bcyc[$];
  int          first_valid, done_cyc, done_cnt, hold_err;
  bit          timed_out, post_valid, post_ready, post_done;

  square_seq_ctrl #(.IDX_W(16), .SQR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_start_i(cmd_start_i), .cmd_count_i(cmd_count_i),
    .abort_i(abort_i),
    .sqr_valid_o(sqr_valid_o), .sqr_ready_i(sqr_ready_i),
    .sqr_o(sqr_o), .sqr_last_o(sqr_last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: beat k of a command started at n0 is (n0+k)^2 truncated to 32 bits
  function automatic logic [31:0] ref_sq(input longint unsigned n);
    longint unsigned p;
    p = n * n;
    return p[31:0];
  endfunction

  task automatic send_cmd(input logic [15:0] s, input logic [15:0] n);
    cmd_start_i = s;
    cmd_count_i = n;
    cmd_valid_i = 1'b1;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  // Monitor: cycle 1 is the cycle right after the accept edge.
  // rmode 0: always ready, 1: ready on odd cycles, 2: random ready plus junk commands.
  task automatic collect(input int max_cyc, input int rmode, input int abort_after);
    int          c;
    bit          stall, fin, r;
    logic [31:0] held;
    bit          held_last;
    beats.delete(); lasts.delete(); bcyc.delete();
    first_valid = 0; done_cyc = 0; done_cnt = 0; hold_err = 0; timed_out = 0;
    c = 1; stall = 0; fin = 0; held = '0; held_last = 0;
    while (!fin) begin
      if (stall && (!sqr_valid_o || sqr_o !== held || sqr_last_o !== held_last)) hold_err++;
      if (sqr_valid_o && first_valid == 0) first_valid = c;
      if (done_o) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
        fin = 1;
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = (c % 2 == 1);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (rmode == 2) begin
        cmd_valid_i = 1'($urandom_range(0, 1));
        cmd_start_i = 16'($urandom);
        cmd_count_i = 16'($urandom);
      end
      sqr_ready_i = r;
      stall = sqr_valid_o && !r;
      held = sqr_o;
      held_last = sqr_last_o;
      if (sqr_valid_o && r) begin
        beats.push_back(sqr_o);
        lasts.push_back(sqr_last_o);
        bcyc.push_back(c);
        if (abort_after != 0 && beats.size() == abort_after) begin
          abort_i = 1'b1;
          fin = 1;
        end
      end
      if (c >= max_cyc) begin
        timed_out = 1;
        fin = 1;
      end
      @(posedge clk); #1;
      c++;
      abort_i = 1'b0;
      cmd_valid_i = 1'b0;
      sqr_ready_i = 1'b0;
    end
    post_valid = sqr_valid_o;
    post_ready = cmd_ready_o;
    post_done  = done_o;
  endtask

  task automatic test_reset;
    n_cmp++; if (sqr_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", sqr_valid_o); end
    n_cmp++; if (sqr_last_o !== 1'b0) begin n_bad++; $display("FAIL rst_last: got %b want 0", sqr_last_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    n_cmp++; if (sqr_o !== 32'h0) begin n_bad++; $display("FAIL rst_sqr: got %h want 0", sqr_o); end
    n_cmp++; if (cmd_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", cmd_ready_o); end
  endtask

  task automatic test_basic;
    send_cmd(16'd0, 16'd4);
    collect(80, 0, 0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL basic_timeout: got timeout want done"); end
    n_cmp++; if (beats.size() !== 4) begin n_bad++; $display("FAIL basic_beats: got %0d want 4", beats.size()); end
    for (int k = 0; k < beats.size() && k < 4; k++) begin
      n_cmp++; if (beats[k] !== ref_sq(longint'(k))) begin n_bad++; $display("FAIL basic_val[%0d]: got %h want %h", k, beats[k], ref_sq(longint'(k))); end
      n_cmp++; if (lasts[k] !== (k == 3)) begin n_bad++; $display("FAIL basic_last[%0d]: got %b want %b", k, lasts[k], (k == 3)); end
    end
    n_cmp++; if (first_valid !== 17) begin n_bad++; $display("FAIL basic_latency: got %0d want 17", first_valid); end
    if (bcyc.size() == 4) begin
      n_cmp++; if (done_cyc !== bcyc[3] + 1) begin n_bad++; $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc, bcyc[3] + 1); end
      n_cmp++; if (bcyc[3] - bcyc[0] !== 3) begin n_bad++; $display("FAIL basic_b2b: got span %0d want 3", bcyc[3] - bcyc[0]); end
    end
    n_cmp++; if (post_ready !== 1'b1) begin n_bad++; $display("FAIL basic_idle: got ready %b want 1", post_ready); end
  endtask

  task automatic test_backpressure;
    send_cmd(16'd3, 16'd3);
    collect(80, 1, 0);
    n_cmp++; if (beats.size() !== 3) begin n_bad++; $display("FAIL bp_beats: got %0d want 3", beats.size()); end
    for (int k = 0; k < beats.size() && k < 3; k++) begin
      n_cmp++; if (beats[k] !== ref_sq(longint'(3 + k))) begin n_bad++; $display("FAIL bp_val[%0d]: got %h want %h", k, beats[k], ref_sq(longint'(3 + k))); end
    end
    n_cmp++; if (hold_err !== 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_err); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL bp_done: got %0d pulses want 1", done_cnt); end
  endtask

  task automatic test_zero_count;
    send_cmd(16'd7, 16'd0);
    collect(20, 0, 0);
    n_cmp++; if (first_valid !== 0) begin n_bad++; $display("FAIL zero_valid: got valid at cycle %0d want none", first_valid); end
    n_cmp++; if (done_cyc !== 1) begin n_bad++; $display("FAIL zero_done: got cycle %0d want 1", done_cyc); end
    n_cmp++; if (post_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready: got %b want 1", post_ready); end
  endtask

  task automatic test_overflow;
    send_cmd(16'hFFFF, 16'd2);
    collect(80, 0, 0);
    n_cmp++; if (beats.size() !== 2) begin n_bad++; $display("FAIL ovf_beats: got %0d want 2", beats.size()); end
    if (beats.size() == 2) begin
      n_cmp++; if (beats[0] !== ref_sq(64'd65535)) begin n_bad++; $display("FAIL ovf_b0: got %h want %h", beats[0], ref_sq(64'd65535)); end
      n_cmp++; if (beats[1] !== ref_sq(64'd65536)) begin n_bad++; $display("FAIL ovf_b1: got %h want %h", beats[1], ref_sq(64'd65536)); end
      n_cmp++; if (lasts[0] !== 1'b0 || lasts[1] !== 1'b1) begin n_bad++; $display("FAIL ovf_last: got %b%b want 01", lasts[0], lasts[1]); end
    end
  endtask

  task automatic test_abort;
    send_cmd(16'd5, 16'd10);
    collect(80, 0, 2);
    n_cmp++; if (beats.size() !== 2) begin n_bad++; $display("FAIL abort_beats: got %0d want 2", beats.size()); end
    if (beats.size() == 2) begin
      n_cmp++; if (beats[0] !== ref_sq(64'd5) || beats[1] !== ref_sq(64'd6)) begin n_bad++; $display("FAIL abort_vals: got %h %h want %h %h", beats[0], beats[1], ref_sq(64'd5), ref_sq(64'd6)); end
    end
    n_cmp++; if (post_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", post_valid); end
    n_cmp++; if (done_cnt !== 0 || post_done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %0d/%b want 0/0", done_cnt, post_done); end
    n_cmp++; if (post_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", post_ready); end
    // abort in IDLE must not disturb anything
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin n_bad++; $display("FAIL abort_idle: got busy %b ready %b want 0 1", busy_o, cmd_ready_o); end
  endtask

  task automatic test_reset_mid_seed;
    send_cmd(16'd9, 16'd3);
    repeat (4) begin @(posedge clk); #1; end
    n_cmp++; if (busy_o !== 1'b1 || cmd_ready_o !== 1'b0) begin n_bad++; $display("FAIL seed_busy: got busy %b ready %b want 1 0", busy_o, cmd_ready_o); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1 || done_o !== 1'b0) begin n_bad++; $display("FAIL arst_ctrl: got busy %b ready %b done %b want 0 1 0", busy_o, cmd_ready_o, done_o); end
    n_cmp++; if (sqr_valid_o !== 1'b0 || sqr_last_o !== 1'b0 || sqr_o !== 32'h0) begin n_bad++; $display("FAIL arst_data: got v %b l %b d %h want 0 0 0", sqr_valid_o, sqr_last_o, sqr_o); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    send_cmd(16'd2, 16'd1);
    collect(80, 0, 0);
    n_cmp++; if (beats.size() !== 1) begin n_bad++; $display("FAIL arst_beats: got %0d want 1", beats.size()); end
    if (beats.size() == 1) begin
      n_cmp++; if (beats[0] !== ref_sq(64'd2) || lasts[0] !== 1'b1) begin n_bad++; $display("FAIL arst_beat: got %h last %b want %h last 1", beats[0], lasts[0], ref_sq(64'd2)); end
    end
  endtask

  task automatic test_random;
    logic [15:0] s, n;
    for (int t = 0; t < 8; t++) begin
      s = 16'($urandom);
      if (t == 0) s = 16'hFFFD;
      n = 16'($urandom_range(0, 5));
      send_cmd(s, n);
      collect(300, 2, 0);
      n_cmp++; if (timed_out || beats.size() !== int'(n)) begin n_bad++; $display("FAIL rnd%0d_beats: got %0d want %0d", t, beats.size(), n); end
      for (int k = 0; k < beats.size() && k < int'(n); k++) begin
        n_cmp++; if (beats[k] !== ref_sq(longint'(s) + longint'(k)) || lasts[k] !== (k == int'(n) - 1)) begin
          n_bad++; $display("FAIL rnd%0d_beat%0d: got %h last %b want %h last %b", t, k, beats[k], lasts[k], ref_sq(longint'(s) + longint'(k)), (k == int'(n) - 1));
        end
      end
      n_cmp++; if (hold_err !== 0 || done_cnt !== 1) begin n_bad++; $display("FAIL rnd%0d_hs: got hold_err %0d done %0d want 0 1", t, hold_err, done_cnt); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_valid_i = 1'b0; abort_i = 1'b0; sqr_ready_i = 1'b0;
    cmd_start_i = '0; cmd_count_i = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_basic;
    test_backpressure;
    test_zero_count;
    test_overflow;
    test_abort;
    test_reset_mid_seed;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/square_seq_ctrl.md
SQUARE_SEQ_CTRL -- requirements
Module: square_seq_ctrl

Interface
- REQ-001: Parameter IDX_W, default 16, index width; SHALL be fixed at 16 in this release.
- REQ-002: Parameter SQR_W, default 32, square width; SHALL equal 2*IDX_W.
- REQ-003: clk  input  1  rising-edge clock, single clock domain.
- REQ-004: reset_n  input  1  asynchronous, active-low reset.
- REQ-005: cmd_valid_i  input  1  command offered.
- REQ-006: cmd_ready_o  output  1  command accepted when cmd_valid_i is also high; SHALL be high only in IDLE.
- REQ-007: cmd_start_i  input  IDX_W  first index n0.
- REQ-008: cmd_count_i  input  IDX_W  number of squares to emit.
- REQ-009: abort_i  input  1  terminate the active command.
- REQ-010: sqr_valid_o  output  1  output beat valid.
- REQ-011: sqr_ready_i  input  1  consumer ready.
- REQ-012: sqr_o  output  SQR_W  square value.
- REQ-013: sqr_last_o  output  1  final beat of the command.
- REQ-014: busy_o  output  1  state is not IDLE.
- REQ-015: done_o  output  1  one-cycle pulse on normal completion.

Function
- REQ-016: FSM states SHALL be IDLE, SEED, STREAM, DONE.
- REQ-017: IDLE->SEED on cmd_valid_i & cmd_ready_o; start and count SHALL be latched on that edge.
- REQ-018: SEED SHALL compute n0*n0 by 16-cycle shift-add, with no combinational multiplier; it SHALL last exactly 16 cycles.
- REQ-019: First sqr_valid_o SHALL assert 17 cycles after the accept edge.
- REQ-020: If latched count is 0, SEED SHALL be skipped. The FSM SHALL go IDLE->DONE, so done_o is high the cycle after accept and no beat is emitted.
- REQ-021: In STREAM, beat k (k = 0..count-1) SHALL carry (n0+k)^2 mod 2^32.
- REQ-022: Successive beats SHALL be produced incrementally: square += odd, odd += 2, with odd seeded to 2*n0+1, all modulo 2^32.
- REQ-023: A transfer SHALL occur when sqr_valid_o & sqr_ready_i are both high; the datapath SHALL advance only on a transfer.
- REQ-024: While sqr_valid_o is high and sqr_ready_i is low, sqr_o and sqr_last_o SHALL hold stable.
- REQ-025: sqr_valid_o SHALL not deassert without a transfer, except on abort.
- REQ-026: sqr_last_o SHALL be high exactly on beat count-1.
- REQ-027: After the last transfer, the FSM SHALL enter DONE for one cycle (done_o=1), then return to IDLE.
- REQ-028: Back-to-back sqr_valid_o SHALL be sustained (one beat per cycle) while sqr_ready_i=1.
- REQ-029: abort_i in SEED or STREAM SHALL return the FSM to IDLE on the next edge: sqr_valid_o low, no done_o pulse.
- REQ-030: If a transfer coincides with abort_i, the beat SHALL count as delivered and abort SHALL still take effect.
- REQ-031: abort_i SHALL be ignored in IDLE and DONE.
- REQ-032: Index overflow past 2^16-1 SHALL NOT wrap the index; squares SHALL continue modulo 2^32 per REQ-021.
- REQ-033: cmd_* inputs SHALL be ignored while busy_o is high.

Reset
- REQ-034: On reset_n low, state SHALL go to IDLE immediately (asynchronously), from any state including mid-SEED or mid-STREAM.
- REQ-035: Reset values SHALL be: sqr_valid_o=0, sqr_last_o=0, done_o=0, busy_o=0, sqr_o=0, cmd_ready_o=1.
- REQ-036: All internal registers (square, odd, count, shift-add accumulators) SHALL reset to 0.

Structure
- REQ-037: Package square_seq_pkg SHALL hold IDX_W, SQR_W, and the state enum typedef.
- REQ-038: Sub-module square_step SHALL own the square/odd registers, with load (square, odd) and advance ports.
- REQ-039: square_seq_ctrl SHALL own the FSM, count register, seed multiplier and handshake.

Verification
- REQ-040: start=0, count=4, ready=1 -> beats 0, 1, 4, 9; last on 9; first valid 17 cycles after accept; done_o the cycle after the 9 transfer.
- REQ-041: start=3, count=3, ready toggled 1/0 per cycle -> 9, 16, 25, each held stable while ready=0; exactly 3 transfers.
- REQ-042: count=0, start=7 -> no sqr_valid_o; done_o high the cycle after accept; cmd_ready_o high the following cycle.
- REQ-043: start=65535, count=2 -> 0xFFFE0001 then 0x00000000, last on second beat.
- REQ-044: start=5, count=10, abort_i pulsed after 2 transfers (25, 36) -> sqr_valid_o low next cycle, no done_o, cmd_ready_o high.
- REQ-045: reset_n driven low 5 cycles into SEED -> all outputs at reset values immediately; after release, a new start=2, count=1 command -> single beat 4.
